// File: rtl/sysid_reader_master_if.sv
// ---------------------------------------------------------------------------
// sysid_reader_master_if
//
// Avalon-MM read-only bus between the system-ID reader master and the
// system-ID slave. Carries no clock or reset; both sides run on the shared
// system clock.
//
// Signals:
//   avm_address      master -> slave  word select (0 = system ID, 1 = timestamp)
//   avm_read         master -> slave  read request
//   avm_waitrequest  slave  -> master stall; read completes when low with read high
//   avm_readdata     slave  -> master 32-bit read data, valid on the completing cycle
//
// Modports: master (used by sysid_reader_master), slave (used by the ID slave).
// ---------------------------------------------------------------------------
interface sysid_reader_master_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/sysid_reader_master.sv
// ---------------------------------------------------------------------------
// sysid_reader_master
//
// Avalon-MM read master that interrogates the system-ID slave. On a start
// pulse it reads word 0 (system ID) and word 1 (build timestamp), compares
// both against build-time expected values and reports the result to
// boot/health logic so host software can be gated on a matching image.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous active-high reset
//   start            in   single-cycle pulse that begins a check sequence
//   bus              mst  Avalon-MM read bus (sysid_reader_master_if.master)
//   id_value         out  captured word 0
//   timestamp_value  out  captured word 1
//   busy             out  sequence in progress (read states and compare)
//   done             out  sequence finished; sticky until the next start
//   id_ok            out  id_value == EXPECTED_ID, valid while done
//   ts_ok            out  timestamp_value == EXPECTED_TIMESTAMP, valid while done
//   timeout_err      out  a read stalled too long; sticky until the next start
//
// Optional build macro:
//   SYSID_AUTOSTART_EN  when defined, the first cycle after reset release acts
//                       as an internal start pulse so the check runs once on
//                       its own. External start keeps working afterwards.
// ---------------------------------------------------------------------------
module sysid_reader_master #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1488227433,
    // Legal range 1..255 (8-bit stall counter).
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    sysid_reader_master_if.master         bus,
    output logic [31:0]                   id_value,
    output logic [31:0]                   timestamp_value,
    output logic                          busy,
    output logic                          done,
    output logic                          id_ok,
    output logic                          ts_ok,
    output logic                          timeout_err
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRdId  = 3'd1;
    localparam logic [2:0] StRdTs  = 3'd2;
    localparam logic [2:0] StCheck = 3'd3;
    localparam logic [2:0] StFin   = 3'd4;

    // Abort fires on the stall cycle that would bring the count to
    // TIMEOUT_CYCLES, so avm_read is high for exactly TIMEOUT_CYCLES stalls.
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_address_q, avm_address_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        start_eff;
    logic        completing;
    logic        stalled;
    logic        tmo_hit;

`ifdef SYSID_AUTOSTART_EN
    // High only in the first cycle after reset release.
    logic auto_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= 1'b0;
        end
    end

    assign start_eff = start | auto_q;
`else
    assign start_eff = start;
`endif

    assign completing = avm_read_q & ~bus.avm_waitrequest;
    assign stalled    = avm_read_q &  bus.avm_waitrequest;
    assign tmo_hit    = stalled & (cnt_q == TmoLast);

    always_comb begin
        state_d       = state_q;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        done_d        = done_q;
        id_ok_d       = id_ok_q;
        ts_ok_d       = ts_ok_q;
        timeout_d     = timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            StIdle, StFin: begin
                if (state_q == StFin) begin
                    done_d = 1'b1;
                end
                if (start_eff) begin
                    state_d       = StRdId;
                    avm_read_d    = 1'b1;
                    avm_address_d = 1'b0;
                    cnt_d         = 8'd0;
                    done_d        = 1'b0;
                    id_ok_d       = 1'b0;
                    ts_ok_d       = 1'b0;
                    timeout_d     = 1'b0;
                end
            end

            StRdId: begin
                if (completing) begin
                    id_value_d    = bus.avm_readdata;
                    state_d       = StRdTs;
                    // Drop read for one cycle; the next address is set up now.
                    avm_read_d    = 1'b0;
                    avm_address_d = 1'b1;
                    cnt_d         = 8'd0;
                end else if (tmo_hit) begin
                    state_d    = StFin;
                    avm_read_d = 1'b0;
                    timeout_d  = 1'b1;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    done_d     = 1'b1;
                end else if (stalled) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StRdTs: begin
                if (!avm_read_q) begin
                    // Gap cycle after the ID read; issue the timestamp read.
                    avm_read_d = 1'b1;
                end else if (completing) begin
                    ts_value_d = bus.avm_readdata;
                    state_d    = StCheck;
                    avm_read_d = 1'b0;
                end else if (tmo_hit) begin
                    state_d    = StFin;
                    avm_read_d = 1'b0;
                    timeout_d  = 1'b1;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    done_d     = 1'b1;
                end else if (stalled) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            StCheck: begin
                id_ok_d = (id_value_q == EXPECTED_ID);
                ts_ok_d = (ts_value_q == EXPECTED_TIMESTAMP);
                state_d = StFin;
            end

            default: begin
                state_d    = StIdle;
                avm_read_d = 1'b0;
            end
        endcase

        busy_d = (state_d == StRdId) || (state_d == StRdTs) || (state_d == StCheck);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            id_value_q    <= 32'd0;
            ts_value_q    <= 32'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_ok_q       <= 1'b0;
            ts_ok_q       <= 1'b0;
            timeout_q     <= 1'b0;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_ok_q       <= id_ok_d;
            ts_ok_q       <= ts_ok_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.avm_read    = avm_read_q;
    assign bus.avm_address = avm_address_q;
    assign id_value        = id_value_q;
    assign timestamp_value = ts_value_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout_err     = timeout_q;

endmodule
